oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
// - Bus scheduler between the cpu core and the sprite OAM DMA engine. A cpu write to
//   DMA_REG_ADDR latches a source page, stalls the cpu via cpu_ready, then copies XFER_LEN
//   bytes from {page,idx} to OAM_DATA_ADDR.
// - Sits between the cpu ports (addr/d_out/write) and the system bus; the cpu regains
//   the bus when the transfer ends.
// PARAMETERS
// - DMA_REG_ADDR   16'h4014  cpu write address that triggers DMA; the written byte is the source page
// - OAM_DATA_ADDR  16'h2004  destination address for every DMA write
// - XFER_LEN       256       bytes per transfer, 1..256
// PORTS
// - clk         in   1   single clock
// - reset       in   1   synchronous, active-high
// - cpu_addr    in   16  cpu address
// - cpu_d_out   in   8   cpu write data
// - cpu_write   in   1   cpu write strobe
// - cpu_ready   out  1   1 = cpu may advance; 0 = cpu stalled
// - bus_d_in    in   8   read data returned from system bus
// - bus_addr    out  16  system bus address
// - bus_d_out   out  8   system bus write data
// - bus_write   out  1   system bus write strobe
// - dma_active  out  1   1 whenever state != IDLE
// BEHAVIOUR
// - Reset values: state=IDLE, page=0, idx=0, data_q=0, odd=0, cpu_ready=1, dma_active=0.
// - odd: 1-bit cycle-parity flop, toggles every clk from reset. It is never cleared by a DMA.
// - States: IDLE, HALT, ALIGN, READ, WRITE.
//   - IDLE:  bus_* = cpu_* (combinational pass-through). cpu_ready=1.
//            If cpu_write && cpu_addr==DMA_REG_ADDR: page<=cpu_d_out, idx<=0, next=HALT.
//            The trigger write itself also reaches the bus.
//   - HALT:  1 cycle. bus_addr=cpu_addr, bus_write=0 (dummy read, cpu write suppressed).
//            next = odd ? ALIGN : READ.
//   - ALIGN: 1 cycle. Same bus drive as HALT. next=READ.
//   - READ:  bus_addr={page,idx}, bus_write=0. data_q<=bus_d_in at the clock edge. next=WRITE.
//   - WRITE: bus_addr=OAM_DATA_ADDR, bus_d_out=data_q, bus_write=1.
//            If idx==XFER_LEN-1: next=IDLE, idx<=0.
//            Otherwise idx<=idx+1, next=READ.
// - cpu_ready and dma_active are decoded from the state, with no extra register stage:
//   cpu_ready=(state==IDLE), dma_active=!cpu_ready.
// - Stall length: 1+2*XFER_LEN cycles, plus 1 when ALIGN is taken (513/514 at default).
// - Source addresses never cross the page. idx is 8 bits; {page,idx} wraps within page only.
// - bus_d_out is a don't-care when bus_write=0. Drive cpu_d_out in IDLE and data_q in DMA states.
// - Trigger writes while state!=IDLE are ignored. They cannot reach the bus, since bus_write
//   follows DMA.
// - reset asserted mid-transfer: next edge forces IDLE and cpu_ready=1. The partial copy
//   is abandoned and not resumed.
// - No combinational path from bus_d_in to any output.
// STRUCTURE
// - nes_pkg holds:
//   - typedef enum logic [2:0] {IDLE,HALT,ALIGN,READ,WRITE} dma_state_t
//   - the address constants DMA_REG_ADDR and OAM_DATA_ADDR (shared with the PPU register decode)
// - No sub-module. The state flop, idx counter, page/data_q latches, parity flop and the
//   output mux are all in this module.
// TESTING
// - Even start: write 8'h02 to 16'h4014 with odd=0 at HALT
//   -> cpu_ready low exactly 513 cycles; READ addrs 0200..02FF; 256 writes to 2004.
// - Odd start: same trigger with odd=1 at HALT
//   -> ALIGN taken; cpu_ready low 514 cycles; first READ addr 0200.
// - Data path: memory model returns ~addr[7:0]
//   -> write k to 2004 carries 8'hFF-k; bus_write high only in WRITE cycles.
// - Cpu write suppression: cpu_write=1, cpu_addr=0x0000 held during DMA
//   -> no bus write to 0x0000; 4014 re-trigger mid-DMA leaves page unchanged.
// - Reset mid-op: assert reset at idx=8'h40
//   -> next cycle state=IDLE, cpu_ready=1, bus_* = cpu_*; no further 2004 writes.
// - XFER_LEN=4 build, page 8'hFF -> reads FF00..FF03 only, stall 9 or 10 cycles, then IDLE.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES bus definitions: DMA controller states and the memory-mapped
// register addresses that both the DMA scheduler and the PPU decode use.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // Cpu write here starts a sprite DMA; the written byte is the source page.
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  // PPU OAMDATA port, destination of every DMA write.
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA bus scheduler. Passes the cpu through to the system bus
// while idle; a write to DMA_REG_ADDR stalls the cpu and copies XFER_LEN
// bytes from {page,idx} to OAM_DATA_ADDR, one read/write pair per byte.
// An extra alignment cycle is inserted when the halt lands on an odd cycle.
module oam_dma_ctrl
  import nes_pkg::*;
#(
  parameter int XFER_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic        cpu_ready,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  output logic        dma_active
);

  // Index of the final byte; idx is 8 bits so reads never leave the page.
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       odd_q;
  logic       dma_trigger;

  assign dma_trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

  // State, source page/index, fetched byte and free-running cycle parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      odd_q   <= ~odd_q;
    end
  end

  // Next-state logic and bus ownership mux (cpu pass-through unless DMA owns it).
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_write = cpu_write;
    case (state_q)
      IDLE: begin
        // The trigger write itself still reaches the bus.
        if (dma_trigger) begin
          page_d  = cpu_d_out;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // Dummy read at the cpu address; any cpu write is swallowed.
        bus_write = 1'b0;
        bus_d_out = data_q;
        state_d   = odd_q ? ALIGN : READ;
      end
      ALIGN: begin
        bus_write = 1'b0;
        bus_d_out = data_q;
        state_d   = READ;
      end
      READ: begin
        bus_addr  = {page_q, idx_q};
        bus_write = 1'b0;
        bus_d_out = data_q;
        data_d    = bus_d_in;
        state_d   = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = data_q;
        bus_write = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_ready  = (state_q == IDLE);
  assign dma_active = ~cpu_ready;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Testbench for oam_dma_ctrl: randomized transfers checked against a
// transaction-level expectation of the bus trace during each stall.
module tb_oam_dma_ctrl;
  import nes_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] cpu_addr, bus_addr;
  logic [7:0]  cpu_d_out, bus_d_out, bus_d_in;
  logic        cpu_write, cpu_ready, bus_write, dma_active;

  logic [15:0] s_cpu_addr, s_bus_addr;
  logic [7:0]  s_cpu_d_out, s_bus_d_out, s_bus_d_in;
  logic        s_cpu_write, s_cpu_ready, s_bus_write, s_dma_active;

  logic [7:0] salt;
  int cyc;
  int checks = 0;
  int failures = 0;

  logic [15:0] obs_addr[$], exp_addr[$];
  logic        obs_wr[$],   exp_wr[$];
  logic [7:0]  obs_dat[$],  exp_dat[$];
  int          act_err;

  // Memory model: byte at an address is a simple function of it.
  assign bus_d_in   = ~bus_addr[7:0] ^ salt;
  assign s_bus_d_in = ~s_bus_addr[7:0] ^ salt;

  // Cycles since reset; its LSB is the expected cycle parity.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  oam_dma_ctrl #(.XFER_LEN(256)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
    .cpu_write(cpu_write), .cpu_ready(cpu_ready), .bus_d_in(bus_d_in),
    .bus_addr(bus_addr), .bus_d_out(bus_d_out), .bus_write(bus_write),
    .dma_active(dma_active)
  );

  oam_dma_ctrl #(.XFER_LEN(4)) dut_short (
    .clk(clk), .reset(reset), .cpu_addr(s_cpu_addr), .cpu_d_out(s_cpu_d_out),
    .cpu_write(s_cpu_write), .cpu_ready(s_cpu_ready), .bus_d_in(s_bus_d_in),
    .bus_addr(s_bus_addr), .bus_d_out(s_bus_d_out), .bus_write(s_bus_write),
    .dma_active(s_dma_active)
  );

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return ~a[7:0] ^ salt;
  endfunction

  // Expected stalled-cycle trace: dummy cycle(s) at the cpu address, then
  // one read of {page,k} and one OAM write of that byte per k.
  task automatic build_exp(input logic [7:0] pg, input bit align, input int n,
                           input logic [15:0] hold_addr);
    exp_addr.delete(); exp_wr.delete(); exp_dat.delete();
    for (int i = 0; i < 1 + int'(align); i++) begin
      exp_addr.push_back(hold_addr); exp_wr.push_back(1'b0); exp_dat.push_back(8'h00);
    end
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back({pg, 8'(k)}); exp_wr.push_back(1'b0); exp_dat.push_back(8'h00);
      exp_addr.push_back(OAM_DATA_ADDR); exp_wr.push_back(1'b1);
      exp_dat.push_back(mem_val({pg, 8'(k)}));
    end
  endtask

  function automatic int trace_diff();
    if (obs_addr.size() != exp_addr.size())
      return (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    foreach (exp_addr[i])
      if (obs_addr[i] !== exp_addr[i] || obs_wr[i] !== exp_wr[i] ||
          (exp_wr[i] && obs_dat[i] !== exp_dat[i]))
        return i;
    return -1;
  endfunction

  function automatic string trace_msg(input int d);
    return $sformatf("idx=%0d got addr=%h wr=%b dat=%h need addr=%h wr=%b dat=%h lens=%0d/%0d",
                     d, obs_addr[d], obs_wr[d], obs_dat[d], exp_addr[d], exp_wr[d],
                     exp_dat[d], obs_addr.size(), exp_addr.size());
  endfunction

  // Wait for an idle negedge such that a trigger now sees parity 'align' at HALT.
  task automatic wait_parity(input bit align);
    @(negedge clk);
    while (cyc[0] == align) @(negedge clk);
  endtask

  task automatic fire(input logic [7:0] pg);
    cpu_addr = DMA_REG_ADDR; cpu_write = 1'b1; cpu_d_out = pg;
  endtask

  // Record the bus every cycle while the cpu is stalled.
  task automatic run_capture(input logic [15:0] hold_addr, input logic hold_wr,
                             input int retrig_at, input logic [7:0] retrig_pg,
                             output int stall, output bit to);
    obs_addr.delete(); obs_wr.delete(); obs_dat.delete();
    stall = 0; to = 0; act_err = 0;
    forever begin
      @(negedge clk);
      cpu_addr = hold_addr; cpu_write = hold_wr; cpu_d_out = 8'h5A;
      if (stall == retrig_at) begin
        cpu_addr = DMA_REG_ADDR; cpu_write = 1'b1; cpu_d_out = retrig_pg;
      end
      #1;
      if (cpu_ready) break;
      obs_addr.push_back(bus_addr); obs_wr.push_back(bus_write); obs_dat.push_back(bus_d_out);
      if (dma_active !== 1'b1) act_err++;
      stall++;
      if (stall > 700) begin to = 1; break; end
    end
    cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || s_cpu_ready !== 1'b1 || s_dma_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got ready=%b active=%b s_ready=%b s_active=%b need 1 0 1 0",
               cpu_ready, dma_active, s_cpu_ready, s_dma_active);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'($urandom); d = 8'($urandom); w = 1'($urandom);
      if (a == DMA_REG_ADDR) a = 16'h0000;
      cpu_addr = a; cpu_d_out = d; cpu_write = w;
      #1;
      checks++;
      if (bus_addr !== a || bus_d_out !== d || bus_write !== w || cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
        failures++;
        $display("FAIL idle_passthru got addr=%h d=%h w=%b rdy=%b act=%b need addr=%h d=%h w=%b rdy=1 act=0",
                 bus_addr, bus_d_out, bus_write, cpu_ready, dma_active, a, d, w);
      end
    end
    cpu_write = 1'b0;
  endtask

  task automatic test_even_start();
    int stall; bit to; int d;
    salt = 8'h00;
    wait_parity(1'b0);
    fire(8'h02);
    #1;
    checks++;
    if (bus_addr !== DMA_REG_ADDR || bus_write !== 1'b1 || bus_d_out !== 8'h02) begin
      failures++;
      $display("FAIL trigger_on_bus got addr=%h w=%b d=%h need 4014 1 02", bus_addr, bus_write, bus_d_out);
    end
    build_exp(8'h02, 1'b0, 256, 16'h0000);
    run_capture(16'h0000, 1'b0, -1, 8'h00, stall, to);
    checks++;
    if (stall !== 513 || to) begin
      failures++; $display("FAIL even_stall got %0d need 513", stall);
    end
    checks++;
    if (act_err !== 0) begin
      failures++; $display("FAIL even_dma_active got %0d bad cycles need 0", act_err);
    end
    d = trace_diff();
    checks++;
    if (d >= 0) begin failures++; $display("FAIL even_trace %s", trace_msg(d)); end
  endtask

  task automatic test_odd_start();
    int stall; bit to; int d;
    logic [7:0] pg;
    pg = 8'($urandom_range(1, 254));
    salt = 8'h00;
    wait_parity(1'b1);
    fire(pg);
    build_exp(pg, 1'b1, 256, 16'h0000);
    run_capture(16'h0000, 1'b0, -1, 8'h00, stall, to);
    checks++;
    if (stall !== 514 || to) begin
      failures++; $display("FAIL odd_stall got %0d need 514", stall);
    end
    checks++;
    if (obs_addr.size() < 3 || obs_addr[2] !== {pg, 8'h00}) begin
      failures++; $display("FAIL odd_first_read got %h need %h", obs_addr[2], {pg, 8'h00});
    end
    d = trace_diff();
    checks++;
    if (d >= 0) begin failures++; $display("FAIL odd_trace %s", trace_msg(d)); end
  endtask

  task automatic test_data_path();
    int stall; bit to; int d; int nwr;
    logic [7:0] pg;
    bit al;
    for (int r = 0; r < 2; r++) begin
      pg = 8'($urandom_range(1, 254));
      salt = (r == 0) ? 8'h00 : 8'($urandom);
      al = 1'($urandom);
      wait_parity(al);
      fire(pg);
      build_exp(pg, al, 256, 16'h0000);
      run_capture(16'h0000, 1'b0, -1, 8'h00, stall, to);
      nwr = 0;
      foreach (obs_wr[i]) if (obs_wr[i] === 1'b1 && obs_addr[i] === OAM_DATA_ADDR) nwr++;
      checks++;
      if (nwr !== 256) begin
        failures++; $display("FAIL data_write_count got %0d need 256", nwr);
      end
      d = trace_diff();
      checks++;
      if (d >= 0) begin failures++; $display("FAIL data_trace salt=%h %s", salt, trace_msg(d)); end
    end
  endtask

  task automatic test_cpu_suppress();
    int stall; bit to; int d; int bad; int busy;
    logic [7:0] pg;
    bit al;
    pg = 8'($urandom_range(1, 254));
    salt = 8'($urandom);
    al = 1'($urandom);
    wait_parity(al);
    fire(pg);
    build_exp(pg, al, 256, 16'h0000);
    run_capture(16'h0000, 1'b1, $urandom_range(50, 400), pg ^ 8'h55, stall, to);
    bad = 0;
    foreach (obs_addr[i]) if (obs_addr[i] === 16'h0000 && obs_wr[i] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL suppress_cpu_write got %0d leaked writes need 0", bad);
    end
    d = trace_diff();
    checks++;
    if (d >= 0) begin failures++; $display("FAIL suppress_trace %s", trace_msg(d)); end
    busy = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (cpu_ready !== 1'b1) busy++;
    end
    checks++;
    if (busy !== 0) begin
      failures++; $display("FAIL retrigger_ignored got %0d stalled cycles need 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pg;
    bit found; int nwr;
    pg = 8'($urandom_range(1, 254));
    salt = 8'($urandom);
    wait_parity(1'($urandom));
    fire(pg);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      cpu_addr = 16'h1234; cpu_write = 1'b1; cpu_d_out = 8'hC3;
      #1;
      if (bus_addr === {pg, 8'h40} && bus_write === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_mid_reach got no read of %h need one", {pg, 8'h40});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || bus_addr !== 16'h1234 ||
        bus_write !== 1'b1 || bus_d_out !== 8'hC3) begin
      failures++;
      $display("FAIL reset_mid_idle got rdy=%b act=%b addr=%h w=%b d=%h need 1 0 1234 1 c3",
               cpu_ready, dma_active, bus_addr, bus_write, bus_d_out);
    end
    @(negedge clk);
    reset = 1'b0; cpu_write = 1'b0;
    nwr = 0;
    repeat (600) begin
      @(negedge clk); #1;
      if (bus_write === 1'b1 && bus_addr === OAM_DATA_ADDR) nwr++;
    end
    checks++;
    if (nwr !== 0) begin
      failures++; $display("FAIL reset_mid_abandon got %0d oam writes need 0", nwr);
    end
  endtask

  task automatic test_back_to_back();
    int stall; bit to; int d;
    logic [7:0] pg;
    bit al;
    salt = 8'($urandom);
    wait_parity(1'($urandom));
    for (int r = 0; r < 2; r++) begin
      pg = 8'($urandom_range(1, 254));
      al = ~cyc[0];
      fire(pg);
      build_exp(pg, al, 256, 16'h0000);
      run_capture(16'h0000, 1'b0, -1, 8'h00, stall, to);
      checks++;
      if (stall !== 513 + int'(al) || to) begin
        failures++; $display("FAIL b2b_stall run=%0d got %0d need %0d", r, stall, 513 + int'(al));
      end
      d = trace_diff();
      checks++;
      if (d >= 0) begin failures++; $display("FAIL b2b_trace run=%0d %s", r, trace_msg(d)); end
    end
  endtask

  task automatic test_short_xfer();
    logic [15:0] rd[$];
    logic [15:0] last_rd;
    int stall, nwr, bad;
    bit ok;
    salt = 8'($urandom);
    for (int a = 0; a < 2; a++) begin
      wait_parity(1'(a));
      s_cpu_addr = DMA_REG_ADDR; s_cpu_write = 1'b1; s_cpu_d_out = 8'hFF;
      rd.delete(); stall = 0; nwr = 0; bad = 0; last_rd = 16'h0000;
      forever begin
        @(negedge clk);
        s_cpu_addr = 16'h0000; s_cpu_write = 1'b0;
        #1;
        if (s_cpu_ready) break;
        stall++;
        if (!s_bus_write && s_bus_addr !== 16'h0000) begin
          rd.push_back(s_bus_addr); last_rd = s_bus_addr;
        end
        if (s_bus_write) begin
          nwr++;
          if (s_bus_addr !== OAM_DATA_ADDR || s_bus_d_out !== mem_val(last_rd)) bad++;
        end
        if (stall > 40) break;
      end
      checks++;
      if (stall !== 9 + a) begin
        failures++; $display("FAIL short_stall align=%0d got %0d need %0d", a, stall, 9 + a);
      end
      ok = (rd.size() == 4);
      for (int k = 0; k < 4 && ok; k++) if (rd[k] !== {8'hFF, 8'(k)}) ok = 0;
      checks++;
      if (!ok) begin
        failures++; $display("FAIL short_reads align=%0d got %0d reads first=%h need FF00..FF03",
                             a, rd.size(), rd[0]);
      end
      checks++;
      if (nwr !== 4 || bad !== 0) begin
        failures++; $display("FAIL short_writes align=%0d got %0d writes %0d bad need 4 0", a, nwr, bad);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_write = 1'b0;
    s_cpu_addr = 16'h0000; s_cpu_d_out = 8'h00; s_cpu_write = 1'b0;
    salt = 8'h00;
    test_reset();
    test_even_start();
    test_odd_start();
    test_data_path();
    test_cpu_suppress();
    test_reset_mid();
    test_back_to_back();
    test_short_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
